// File: rtl/cla_arb_pkg.sv
// Shared types, constants and the round-robin search function for the
// cla_share_arb arbiter and its picker.
package cla_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CLA_WIDTH = 18;
  localparam int CNT_W     = 16;
  // Largest supported requester count; the search function works on
  // vectors of this width and callers zero-extend into it.
  localparam int MAX_REQ   = 16;

  // Round-robin search: the first valid requester strictly after ptr,
  // wrapping modulo nreq. Returns a one-hot grant (all zero if none valid).
  // Because the search covers nreq positions, ptr itself is tried last,
  // so a lone valid requester is always granted.
  function automatic logic [MAX_REQ-1:0] rr_next(
    input logic [3:0]         ptr,
    input logic [MAX_REQ-1:0] valid,
    input int                 nreq
  );
    logic [MAX_REQ-1:0] grant;
    logic               found;
    int                 idx;
    grant = '0;
    found = 1'b0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      if (i <= nreq) begin
        idx = (int'(ptr) + i) % nreq;
        if (!found && valid[idx[3:0]]) begin
          grant[idx[3:0]] = 1'b1;
          found           = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/cla_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   i_valid  request valid vector
//   i_ptr    index of the most recently granted requester
//   o_grant  one-hot grant (zero when nothing is valid)
//   o_idx    binary index of the granted requester
//   o_any    at least one requester granted
module cla_rr_pick
  import cla_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [ID_W-1:0] i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [ID_W-1:0] o_idx,
  output logic            o_any
);

  logic [MAX_REQ-1:0] w_valid_ext;
  logic [MAX_REQ-1:0] w_grant_ext;

  assign w_valid_ext = MAX_REQ'(i_valid);
  assign w_grant_ext = rr_next(4'(i_ptr), w_valid_ext, NREQ);

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_grant
      assign o_grant[gi] = w_grant_ext[gi];
    end
  endgenerate

  // Bits above NREQ are always zero, so OR-ing the full vector is safe.
  assign o_any = |w_grant_ext;

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (o_grant[i]) o_idx = o_idx | ID_W'(i);
    end
  end

endmodule

// File: rtl/cla_share_arb.sv
// Round-robin arbiter/sequencer sharing one combinational carry-lookahead
// adder among NREQ requesters. Operands are registered before driving the
// adder; the sum is registered and returned with the requester index.
// Optional build macro: CLA_ARB_STATS_EN adds o_carry_cnt and o_busy.
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_req_valid / o_req_ready per-requester handshake (ready one-hot or zero)
//   i_req_add1 / i_req_add2   packed operands, requester k at [k*WIDTH +: WIDTH]
//   o_add1 / o_add2           registered operands to the shared adder
//   i_add_result              adder sum, bit WIDTH is carry-out
//   o_rsp_valid / i_rsp_ready response handshake
//   o_rsp_result / o_rsp_id   registered sum and owning requester index
//   o_carry_cnt, o_busy       (stats build only) saturating carry count, busy
module cla_share_arb
  import cla_arb_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = CLA_WIDTH,
  localparam int ID_W  = $clog2(NREQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NREQ-1:0]       i_req_valid,
  output logic [NREQ-1:0]       o_req_ready,
  input  logic [NREQ*WIDTH-1:0] i_req_add1,
  input  logic [NREQ*WIDTH-1:0] i_req_add2,
  output logic [WIDTH-1:0]      o_add1,
  output logic [WIDTH-1:0]      o_add2,
  input  logic [WIDTH:0]        i_add_result,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [WIDTH:0]        o_rsp_result,
  output logic [ID_W-1:0]       o_rsp_id
`ifdef CLA_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]      o_carry_cnt,
  output logic                  o_busy
`endif
);

  state_t            r_state;
  state_t            w_state_next;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_idx;
  logic [WIDTH-1:0]  r_add1;
  logic [WIDTH-1:0]  r_add2;
  logic              r_rsp_valid;
  logic [WIDTH:0]    r_rsp_result;
  logic [ID_W-1:0]   r_rsp_id;

  logic [NREQ-1:0]   w_grant;
  logic [ID_W-1:0]   w_idx;
  logic              w_any;
  logic              w_grant_en;
  logic              w_accept;
  logic [WIDTH-1:0]  w_op1 [NREQ];
  logic [WIDTH-1:0]  w_op2 [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_op1[gi] = i_req_add1[gi*WIDTH +: WIDTH];
      assign w_op2[gi] = i_req_add2[gi*WIDTH +: WIDTH];
    end
  endgenerate

  cla_rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .i_valid (i_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Grants are offered in IDLE, and in RESP only in the cycle the response
  // is consumed, which gives back-to-back accept without a bubble.
  always_comb begin
    w_state_next = r_state;
    w_grant_en   = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_grant_en = 1'b1;
        if (w_any) w_state_next = CALC;
      end
      CALC: w_state_next = RESP;
      RESP: begin
        if (i_rsp_ready) begin
          w_grant_en   = 1'b1;
          w_state_next = w_any ? CALC : IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign o_req_ready = w_grant_en ? w_grant : '0;
  assign w_accept    = w_grant_en & w_any;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_ptr        <= ID_W'(NREQ - 1);
      r_idx        <= '0;
      r_add1       <= '0;
      r_add2       <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_id     <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_add1 <= w_op1[w_idx];
        r_add2 <= w_op2[w_idx];
        r_idx  <= w_idx;
        r_ptr  <= w_idx;
      end
      if (r_state == CALC) begin
        r_rsp_result <= i_add_result;
        r_rsp_id     <= r_idx;
        r_rsp_valid  <= 1'b1;
      end else if (r_state == RESP && i_rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign o_add1       = r_add1;
  assign o_add2       = r_add2;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_id     = r_rsp_id;

`ifdef CLA_ARB_STATS_EN
  logic [CNT_W-1:0] r_carry_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_carry_cnt <= '0;
    end else if (r_rsp_valid && i_rsp_ready && r_rsp_result[WIDTH] &&
                 (r_carry_cnt != {CNT_W{1'b1}})) begin
      r_carry_cnt <= r_carry_cnt + 1'b1;
    end
  end

  assign o_carry_cnt = r_carry_cnt;
  assign o_busy      = (r_state != IDLE);
`endif

endmodule

// File: tb/tb_cla_share_arb.sv
module tb_cla_share_arb;
  import cla_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 18;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      req_valid = '0;
  wire  [3:0]      req_ready;
  logic [4*W-1:0]  a1 = '0;
  logic [4*W-1:0]  a2 = '0;
  wire  [W-1:0]    add1;
  wire  [W-1:0]    add2;
  wire  [W:0]      add_result;
  wire             rsp_valid;
  logic            rsp_ready = 1'b1;
  wire  [W:0]      rsp_result;
  wire  [1:0]      rsp_id;
`ifdef CLA_ARB_STATS_EN
  wire  [15:0]     carry_cnt;
  wire             busy;
`endif

  always #5 clk = ~clk;

  // Behavioural stand-in for the shared adder instance.
  assign add_result = {1'b0, add1} + {1'b0, add2};

  cla_share_arb #(.NREQ(NREQ), .WIDTH(W)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_add1   (a1),
    .i_req_add2   (a2),
    .o_add1       (add1),
    .o_add2       (add2),
    .i_add_result (add_result),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_result (rsp_result),
    .o_rsp_id     (rsp_id)
`ifdef CLA_ARB_STATS_EN
    ,
    .o_carry_cnt  (carry_cnt),
    .o_busy       (busy)
`endif
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [20:0] exp_q[$];   // {id[1:0], result[18:0]}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Scoreboard monitor: compares every completed response handshake.
  always @(negedge clk) begin
    logic [20:0] e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rsp: got result %0h id %0d expected none", rsp_result, rsp_id);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_result", 32'(rsp_result), 32'(e[18:0]));
        chk("rsp_id", 32'(rsp_id), 32'(e[20:19]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for all expected responses; always ends at posedge+1.
  task automatic wait_drain();
    int k;
    k = 0;
    do begin
      @(posedge clk);
      k++;
    end while (exp_q.size() != 0 && k < 40);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // One isolated request from requester k; call from IDLE at posedge+1.
  task automatic single(input int k, input logic [17:0] a, input logic [17:0] b,
                        input logic [18:0] exp_sum);
    a1[k*W +: W] = a;
    a2[k*W +: W] = b;
    req_valid    = 4'(1 << k);
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(1 << k));
    exp_q.push_back({2'(k), exp_sum});
    step();
    req_valid = '0;
    @(negedge clk);
    chk("calc_add1", 32'(add1), 32'(a));
    chk("calc_add2", 32'(add2), 32'(b));
    chk("calc_rsp_valid", 32'(rsp_valid), 32'd0);
`ifdef CLA_ARB_STATS_EN
    chk("calc_busy", 32'(busy), 32'd1);
`endif
    step();
    @(negedge clk);
    chk("rsp_valid_n2", 32'(rsp_valid), 32'd1);
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    int acc, last, cyc;

    // Reset state
    step();
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_add1", 32'(add1), 32'd0);
    chk("rst_add2", 32'(add2), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    step();
    rst = 1'b0;

    // Single request with carry-out
    single(0, 18'h3FFFF, 18'h00001, 19'h40000);

    // All four valid continuously, from a fresh pointer
    do_reset();
    for (int k = 0; k < 4; k++) begin
      a1[k*W +: W] = 18'(k + 1);
      a2[k*W +: W] = 18'(2 * k);
    end
    exp_q.push_back({2'd0, 19'd1});
    exp_q.push_back({2'd1, 19'd4});
    exp_q.push_back({2'd2, 19'd7});
    exp_q.push_back({2'd3, 19'd10});
    exp_q.push_back({2'd0, 19'd1});
    req_valid = 4'hF;
    acc = 0; last = 0; cyc = 0;
    while (acc < 5 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (req_ready != 4'd0) begin
        chk("rr_grant", 32'(req_ready), 32'(1 << order[acc]));
        if (acc > 0) chk("rr_spacing", 32'(cyc - last), 32'd2);
        last = cyc;
        acc++;
      end
    end
    if (acc < 5) begin
      n_vec++; n_err++;
      $display("FAIL rr_accepts: got %0d expected 5", acc);
    end
    step();
    req_valid = '0;
    wait_drain();

    // Backpressure while req2 waits (pointer now 0)
    a1[1*W +: W] = 18'd5;
    a2[1*W +: W] = 18'd6;
    req_valid = 4'b0010;
    @(negedge clk);
    chk("bp_grant1", 32'(req_ready), 32'b0010);
    exp_q.push_back({2'd1, 19'd11});
    step();
    rsp_ready = 1'b0;
    a1[2*W +: W] = 18'd100;
    a2[2*W +: W] = 18'd23;
    req_valid = 4'b0100;
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_result", 32'(rsp_result), 32'd11);
      chk("bp_id", 32'(rsp_id), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    step();
    rsp_ready = 1'b1;
    exp_q.push_back({2'd2, 19'd123});
    @(negedge clk);
    chk("bp_release_grant", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("bp_calc_add1", 32'(add1), 32'd100);
    wait_drain();

    // Reset mid-CALC with req1 in flight (pointer now 2)
    a1[1*W +: W] = 18'd5;
    a2[1*W +: W] = 18'd7;
    req_valid = 4'b0010;
    @(negedge clk);
    chk("mid_grant", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    chk("mid_add1", 32'(add1), 32'd0);
    step();
    // Pointer must be back at 3: {3,0} valid -> 0 wins (stale pointer 1 would pick 3)
    a1[0*W +: W] = 18'd10;
    a2[0*W +: W] = 18'd20;
    a1[3*W +: W] = 18'd1;
    a2[3*W +: W] = 18'd1;
    req_valid = 4'b1001;
    @(negedge clk);
    chk("post_rst_grant", 32'(req_ready), 32'b0001);
    exp_q.push_back({2'd0, 19'd30});
    step();
    req_valid = '0;
    wait_drain();

    // Only req3 valid; second time the pointer is already 3 (wrap search)
    single(3, 18'h20000, 18'h20000, 19'h40000);
    single(3, 18'h20000, 18'h20000, 19'h40000);

`ifdef CLA_ARB_STATS_EN
    do_reset();
    @(negedge clk);
    chk("cnt_reset", 32'(carry_cnt), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    step();
    single(0, 18'h3FFFF, 18'h00001, 19'h40000);
    single(1, 18'd1, 18'd2, 19'd3);
    single(2, 18'h20000, 18'h20000, 19'h40000);
    single(3, 18'd4, 18'd5, 19'd9);
    single(0, 18'h3FFFF, 18'h3FFFF, 19'h7FFFE);
    @(negedge clk);
    chk("cnt_three", 32'(carry_cnt), 32'd3);
    step();
    force dut.r_carry_cnt = 16'hFFFE;
    #1;
    release dut.r_carry_cnt;
    single(1, 18'h3FFFF, 18'h00001, 19'h40000);
    single(2, 18'h3FFFF, 18'h00001, 19'h40000);
    @(negedge clk);
    chk("cnt_saturate", 32'(carry_cnt), 32'hFFFF);
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
